// File: rtl/video_reg_fetch_pkg.sv
// video_pkg: fetch addresses, FSM/field encodings and reset values for video_reg_fetch.
// VIDEO_REG_FETCH_STATUS_EN adds a 7th field (game_over) fetched from 0xB000.
package video_pkg;
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, CAPT = 2'd3;
    typedef enum logic [1:0] {S_IDLE = IDLE, S_ADDR = ADDR, S_WAIT = WAIT, S_CAPT = CAPT} state_e;
    typedef enum logic [2:0] {F_P1_LIVES, F_P2_LIVES, F_DOOR_1, F_DOOR_2, F_POS_1, F_POS_2, F_STATUS} field_e;
`ifdef VIDEO_REG_FETCH_STATUS_EN
    localparam int NUM_FIELDS = 7;
`else
    localparam int NUM_FIELDS = 6;
`endif
    localparam logic [31:0] ADDR_P1_LIVES = 32'h6000;
    localparam logic [31:0] ADDR_P2_LIVES = 32'h7000;
    localparam logic [31:0] ADDR_DOOR_1 = 32'h3000;
    localparam logic [31:0] ADDR_DOOR_2 = 32'h4000;
    localparam logic [31:0] ADDR_POS_1 = 32'h9000;
    localparam logic [31:0] ADDR_POS_2 = 32'hA000;
    localparam logic [31:0] ADDR_STATUS = 32'hB000;
    localparam logic [1:0] LIVES_RST = 2'b11;
    typedef logic [NUM_FIELDS-1:0][1:0] fields_t;
    localparam fields_t COMMIT_RST = fields_t'({LIVES_RST, LIVES_RST});
    function automatic logic [31:0] fetch_addr(logic [2:0] idx);
        case (idx)
            F_P1_LIVES: return ADDR_P1_LIVES;
            F_P2_LIVES: return ADDR_P2_LIVES;
            F_DOOR_1: return ADDR_DOOR_1;
            F_DOOR_2: return ADDR_DOOR_2;
            F_POS_1: return ADDR_POS_1;
            F_POS_2: return ADDR_POS_2;
            default: return ADDR_STATUS;
        endcase
    endfunction
endpackage

// File: rtl/video_reg_fetch_if.sv
// video_reg_fetch_if: video-port read bus between video_reg_fetch (master) and data memory (slave).
interface video_reg_fetch_if;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    modport master (output rd_addr, input rd_data);
    modport slave (input rd_addr, output rd_data);
endinterface

// File: rtl/video_reg_fetch_snapshot_reg.sv
// video_snapshot_reg: working/staged/committed triple buffer; frame_sync commits the newest complete scan.
module video_snapshot_reg
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cap_en,
    input  logic [2:0] cap_idx,
    input  logic [1:0] cap_data,
    input  logic       scan_done,
    input  logic       frame_sync,
    output fields_t    out_q,
    output logic       commit_q
);
    fields_t work_q, work_d, stage_q, stage_d, out_d;
    logic stage_valid_q, stage_valid_d, commit_d;

    // a scan finishing on the frame_sync cycle bypasses staging and commits directly
    always_comb begin
        work_d = work_q;
        if (cap_en) work_d[cap_idx] = cap_data;
        stage_d = scan_done ? work_d : stage_q;
        stage_valid_d = scan_done ? !frame_sync : stage_valid_q && !frame_sync;
        commit_d = frame_sync && (scan_done || stage_valid_q);
        out_d = commit_d ? (scan_done ? work_d : stage_q) : out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            stage_q <= '0;
            stage_valid_q <= 1'b0;
            out_q <= COMMIT_RST;
            commit_q <= 1'b0;
        end else begin
            work_q <= work_d;
            stage_q <= stage_d;
            stage_valid_q <= stage_valid_d;
            out_q <= out_d;
            commit_q <= commit_d;
        end
    end
endmodule

// File: rtl/video_reg_fetch.sv
// video_reg_fetch: scans game registers over the video read port and commits them at frame_sync.
// VIDEO_REG_FETCH_STATUS_EN adds the game_over output fetched as a 7th word.
module video_reg_fetch
    import video_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_sync,
    video_reg_fetch_if.master        mem,
    output logic [1:0]               p1_lives,
    output logic [1:0]               p2_lives,
    output logic [1:0]               correct_door_1,
    output logic [1:0]               correct_door_2,
    output logic [1:0]               player_1_pos,
    output logic [1:0]               player_2_pos,
`ifdef VIDEO_REG_FETCH_STATUS_EN
    output logic                     game_over,
`endif
    output logic                     busy,
    output logic                     commit
);
    logic [1:0] state_q, state_d, wait_q, wait_d;
    logic [2:0] idx_q, idx_d;
    logic scan_done, unused_bits;
    fields_t out;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        wait_d = 2'd0;
        scan_done = state_q == CAPT && idx_q == 3'(NUM_FIELDS - 1);
        case (state_q)
            IDLE: state_d = enable ? ADDR : IDLE;
            ADDR: state_d = RD_LAT == 1 ? CAPT : WAIT;
            WAIT: begin
                wait_d = wait_q + 2'd1;
                state_d = wait_q == 2'(RD_LAT - 2) ? CAPT : WAIT;
            end
            default: begin
                idx_d = scan_done ? 3'd0 : idx_q + 3'd1;
                state_d = scan_done ? IDLE : ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= 3'd0;
            wait_q <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            wait_q <= wait_d;
        end
    end

    // idx is 0 whenever idle, so the address rests at 0x6000 between scans
    assign mem.rd_addr = fetch_addr(idx_q);
    assign busy = state_q != IDLE;

    video_snapshot_reg u_snap (
        .clk       (clk),
        .reset     (reset),
        .cap_en    (state_q == CAPT),
        .cap_idx   (idx_q),
        .cap_data  (mem.rd_data[1:0]),
        .scan_done (scan_done),
        .frame_sync(frame_sync),
        .out_q     (out),
        .commit_q  (commit)
    );

    assign p1_lives = out[F_P1_LIVES];
    assign p2_lives = out[F_P2_LIVES];
    assign correct_door_1 = out[F_DOOR_1];
    assign correct_door_2 = out[F_DOOR_2];
    assign player_1_pos = out[F_POS_1];
    assign player_2_pos = out[F_POS_2];
`ifdef VIDEO_REG_FETCH_STATUS_EN
    assign game_over = out[F_STATUS][0];
    assign unused_bits = ^{mem.rd_data[31:2], out[F_STATUS][1]};
`else
    assign unused_bits = ^mem.rd_data[31:2];
`endif
endmodule

// File: tb/tb_video_reg_fetch.sv
// tb_video_reg_fetch: RD_LAT=1 and RD_LAT=3 instances checked every cycle against a scan-timeline model.
module tb_video_reg_fetch;
    localparam logic [31:0] ADDRS [6] = '{32'h6000, 32'h7000, 32'h3000, 32'h4000, 32'h9000, 32'hA000};
    localparam logic [11:0] RST_OUT = 12'h00F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] en = 2'b00, fs = 2'b00;
    wire [11:0] o0, o1;
    wire c0, c1, b0, b1;
    logic [1:0] mem_val [6];
    logic rand_mem = 1'b0;
    logic [31:0] q [3];
    int n_asserts = 0, n_fail = 0;

    int t [2];
    logic [1:0] pend [2];
    logic [5:0][1:0] work [2], stg [2], com [2];
    logic sv [2], cexp [2];
    int busy_cnt [2], com_cnt [2];

    video_reg_fetch_if m0 ();
    video_reg_fetch_if m1 ();

    video_reg_fetch #(.RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .frame_sync(fs[0]), .mem(m0),
        .p1_lives(o0[1:0]), .p2_lives(o0[3:2]), .correct_door_1(o0[5:4]), .correct_door_2(o0[7:6]),
        .player_1_pos(o0[9:8]), .player_2_pos(o0[11:10]), .busy(b0), .commit(c0)
    );
    video_reg_fetch #(.RD_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .frame_sync(fs[1]), .mem(m1),
        .p1_lives(o1[1:0]), .p2_lives(o1[3:2]), .correct_door_1(o1[5:4]), .correct_door_2(o1[7:6]),
        .player_1_pos(o1[9:8]), .player_2_pos(o1[11:10]), .busy(b1), .commit(c1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(logic [31:0] a);
        logic [31:0] r;
        r = $urandom;
        for (int f = 0; f < 6; f++) if (a == ADDRS[f]) r[1:0] = mem_val[f];
        return r;
    endfunction

    // memories with 1- and 3-cycle read latency; upper bits are junk the DUT must ignore
    always @(posedge clk) begin
        m0.rd_data <= mem_read(m0.rd_addr);
        q[0] <= mem_read(m1.rd_addr);
        q[1] <= q[0];
        q[2] <= q[1];
    end
    assign m1.rd_data = q[2];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scan timeline: t counts cycles since the scan began, field f occupies t in [f*per, (f+1)*per)
    task automatic model_step(int i);
        int per;
        logic done;
        per = (i == 0 ? 1 : 3) + 1;
        done = 1'b0;
        if (reset) begin
            t[i] = -1; work[i] = '0; stg[i] = '0; com[i] = RST_OUT; sv[i] = 1'b0; cexp[i] = 1'b0;
            return;
        end
        if (t[i] >= 0) begin
            if (t[i] % per == 0) pend[i] = mem_val[t[i] / per];
            if (t[i] % per == per - 1) work[i][t[i] / per] = pend[i];
            done = t[i] == 6 * per - 1;
        end
        cexp[i] = fs[i] && (done || sv[i]);
        if (cexp[i]) com[i] = done ? work[i] : stg[i];
        if (done) stg[i] = work[i];
        sv[i] = done ? !fs[i] : sv[i] && !fs[i];
        t[i] = done ? -1 : t[i] >= 0 ? t[i] + 1 : en[i] ? 0 : -1;
    endtask

    task automatic check_inst(int i);
        int per;
        per = (i == 0 ? 1 : 3) + 1;
        chk($sformatf("outputs%0d", i), i ? o1 : o0, com[i]);
        chk($sformatf("commit%0d", i), i ? c1 : c0, cexp[i]);
        chk($sformatf("busy%0d", i), i ? b1 : b0, t[i] >= 0);
        chk($sformatf("rd_addr%0d", i), i ? m1.rd_addr : m0.rd_addr, t[i] >= 0 ? ADDRS[t[i] / per] : 32'h6000);
        busy_cnt[i] += (i ? b1 : b0) ? 1 : 0;
        com_cnt[i] += (i ? c1 : c0) ? 1 : 0;
    endtask

    task automatic cycle();
        if (rand_mem) for (int f = 0; f < 6; f++) mem_val[f] = 2'($urandom);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic until_t(int i, int tt);
        int k;
        k = 0;
        while (t[i] != tt && k < 200) begin
            cycle();
            k++;
        end
        chk("wait_bound", t[i], tt);
    endtask

    initial begin
        mem_val = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
        repeat (4) cycle();
        reset = 1'b0;
        busy_cnt = '{0, 0};
        com_cnt = '{0, 0};
        // one scan on each latency, then a single frame_sync
        en = 2'b11;
        cycle();
        en = 2'b00;
        repeat (30) cycle();
        fs = 2'b11;
        cycle();
        fs = 2'b00;
        chk("lat1_values", o0, 12'h636);
        chk("lat3_values", o1, 12'h636);
        chk("lat1_busy_cycles", busy_cnt[0], 12);
        chk("lat3_busy_cycles", busy_cnt[1], 24);
        chk("lat1_commit_count", com_cnt[0], 1);
        chk("lat3_commit_count", com_cnt[1], 1);
        // frame_sync with nothing staged
        cycle();
        fs = 2'b11;
        cycle();
        fs = 2'b00;
        chk("empty_sync_commit0", c0, 1'b0);
        chk("empty_sync_commit1", c1, 1'b0);
        chk("empty_sync_hold", o0, 12'h636);
        // frame_sync during the 3rd read of a back-to-back second scan
        mem_val = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        en = 2'b01;
        cycle();
        until_t(0, -1);
        mem_val = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        until_t(0, 4);
        fs = 2'b01;
        cycle();
        fs = 2'b00;
        en = 2'b00;
        chk("midscan_commit", c0, 1'b1);
        chk("midscan_p1_lives", o0[1:0], 2'd1);
        chk("midscan_values", o0, 12'hAA9);
        until_t(0, -1);
        chk("midscan_no_partial", o0, 12'hAA9);
        fs = 2'b01;
        cycle();
        fs = 2'b00;
        chk("second_scan_values", o0, 12'hFFF);
        // frame_sync coincident with the final capture
        mem_val = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
        en = 2'b10;
        cycle();
        en = 2'b00;
        until_t(1, 23);
        fs = 2'b10;
        cycle();
        fs = 2'b00;
        chk("coincident_commit", c1, 1'b1);
        chk("coincident_values", o1, 12'h39C);
        cycle();
        fs = 2'b10;
        cycle();
        fs = 2'b00;
        chk("coincident_unstaged", c1, 1'b0);
        chk("coincident_hold", o1, 12'h39C);
        // reset in the middle of a scan
        en = 2'b11;
        repeat (7) cycle();
        reset = 1'b1;
        en = 2'b00;
        cycle();
        chk("rst_outputs0", o0, RST_OUT);
        chk("rst_outputs1", o1, RST_OUT);
        chk("rst_busy0", b0, 1'b0);
        chk("rst_busy1", b1, 1'b0);
        chk("rst_rd_addr1", m1.rd_addr, 32'h6000);
        reset = 1'b0;
        fs = 2'b11;
        cycle();
        fs = 2'b00;
        chk("rst_no_commit0", c0, 1'b0);
        chk("rst_no_commit1", c1, 1'b0);
        // randomized traffic against the model
        rand_mem = 1'b1;
        repeat (1500) begin
            en = 2'($urandom) | 2'($urandom);
            fs[0] = $urandom_range(0, 11) == 0;
            fs[1] = $urandom_range(0, 11) == 0;
            reset = $urandom_range(0, 299) == 0;
            cycle();
        end
        reset = 1'b0;
        en = 2'b00;
        fs = 2'b00;
        repeat (3) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
